// File: rtl/rc5_dec_16bit.sv
// rc5_dec_16bit: 16-bit RC5 decryptor (8-bit half-words, one round) using the encryptor's fixed keys.
// Each round step takes one clock. Valid/ready handshakes sit on both the ciphertext side and the plaintext side.
module rc5_dec_16bit #(
    parameter logic [7:0] S0 = 8'h20,
    parameter logic [7:0] S1 = 8'h10,
    parameter logic [7:0] S2 = 8'hFF,
    parameter logic [7:0] S3 = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] c_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p_out,
    output logic        busy,
    output logic [7:0]  blk_cnt
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RND_B = 3'd1,
        RND_A = 3'd2,
        UNWHT = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d, cnt_q, cnt_d;
    logic [15:0] p_q, p_d;
    logic        out_valid_q, out_valid_d;

    // Rotating the doubled word means a shift of 0 naturally returns x unchanged.
    function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] w;
        w = {x, x} >> n;
        return w[7:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = c_in[15:8];
                    b_d     = c_in[7:0];
                    state_d = RND_B;
                end
            end
            RND_B: begin
                b_d     = rotr(b_q - S3, a_q[2:0]) ^ a_q;
                state_d = RND_A;
            end
            RND_A: begin
                a_d     = rotr(a_q - S2, b_q[2:0]) ^ b_q;
                state_d = UNWHT;
            end
            UNWHT: begin
                p_d         = {a_q - S0, b_q - S1};
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Gating with the state keeps out_valid low in any cycle spent in a corrupted encoding.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q && (state_q == OUT);
    assign p_out     = p_q;
    assign blk_cnt   = cnt_q;
endmodule

// File: tb/tb_rc5_dec_16bit.sv
// tb_rc5_dec_16bit: drives random plaintext through an arithmetic RC5 encryptor model and into the decryptor.
// Also covers handshake timing, stalls, back-to-back blocks, asynchronous reset and counter wrap.
module tb_rc5_dec_16bit;
    logic        clock, reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] c_in, p_out;
    logic [7:0]  blk_cnt, exp_cnt;
    int          total = 0, bad = 0;

    rc5_dec_16bit dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .p_out(p_out), .busy(busy), .blk_cnt(blk_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int rotl(input int x, input int n);
        return ((x << n) | (x >> (8 - n))) % 256;
    endfunction

    // The encryptor's forward rounds, written as plain integer arithmetic.
    function automatic logic [15:0] enc(input logic [15:0] p);
        int a, b;
        a = (int'(p[15:8]) + 32'h20) % 256;
        b = (int'(p[7:0]) + 32'h10) % 256;
        a = (rotl(a ^ b, b % 8) + 32'hFF) % 256;
        b = (rotl(b ^ a, a % 8) + 32'hFF) % 256;
        return 16'(a * 256 + b);
    endfunction

    task automatic run_block(input logic [15:0] c, input logic [15:0] exp, input int stall);
        int          lat;
        logic [15:0] held;
        @(negedge clock);
        check("idle_ready", 16'(in_ready), 16'd1);
        in_valid  = 1'b1;
        c_in      = c;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        c_in     = 16'($urandom);
        lat      = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end while (!out_valid && lat < 20);
        check("latency", 16'(lat), 16'd3);
        if (!out_valid) return;
        check("p_out", p_out, exp);
        held = p_out;
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("stall_valid", 16'(out_valid), 16'd1);
            check("stall_hold", p_out, held);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        exp_cnt++;
        check("valid_drop", 16'(out_valid), 16'd0);
        check("blk_cnt", 16'(blk_cnt), 16'(exp_cnt));
        check("hold_after", p_out, held);
        @(negedge clock);
        check("busy_after", 16'(busy), 16'd0);
    endtask

    initial begin
        logic [15:0] p;
        logic [15:0] outs[$];
        int          acc[$];
        logic [7:0]  prev;
        logic        wrapped;
        int          n;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        c_in      = 16'h0;
        exp_cnt   = 8'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_ready", 16'(in_ready), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_valid", 16'(out_valid), 16'd0);
        check("rst_pout", p_out, 16'h0);
        check("rst_cnt", 16'(blk_cnt), 16'h0);

        run_block(16'h2F9E, 16'h0000, 0);
        run_block(16'h6687, 16'h1234, 6);

        // Back-to-back with in_valid held; c_in is scrambled while the block is busy.
        @(negedge clock);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clock);
            if (acc.size() == 0) c_in = 16'h2F9E;
            else if (outs.size() == 0) c_in = 16'($urandom);
            else if (acc.size() == 1) c_in = 16'h6687;
            else c_in = 16'($urandom);
            if (in_ready && in_valid) acc.push_back(i);
            if (out_valid) outs.push_back(p_out);
        end
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        exp_cnt += 8'd2;
        check("b2b_accepts", 16'(acc.size()), 16'd2);
        check("b2b_outs", 16'(outs.size()), 16'd2);
        if (acc.size() == 2) check("b2b_interval", 16'(acc[1] - acc[0]), 16'd5);
        if (outs.size() == 2) begin
            check("b2b_out0", outs[0], 16'h0000);
            check("b2b_out1", outs[1], 16'h1234);
        end
        check("b2b_cnt", 16'(blk_cnt), 16'(exp_cnt));
        check("b2b_idle", 16'(in_ready), 16'd1);

        // Asynchronous reset in the middle of the RND_A cycle.
        @(negedge clock);
        in_valid = 1'b1;
        c_in     = 16'h2F9E;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        exp_cnt = 8'h0;
        check("arst_valid", 16'(out_valid), 16'd0);
        check("arst_pout", p_out, 16'h0);
        check("arst_cnt", 16'(blk_cnt), 16'h0);
        check("arst_busy", 16'(busy), 16'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check("arst_no_stale", 16'(out_valid), 16'd0);
        end
        run_block(16'h6687, 16'h1234, 1);

        wrapped = 1'b0;
        for (int i = 0; i < 256; i++) begin
            p    = 16'($urandom);
            prev = blk_cnt;
            run_block(enc(p), p, int'($urandom_range(0, 2)));
            if (prev == 8'hFF && blk_cnt == 8'h00) wrapped = 1'b1;
        end
        check("cnt_wrap", 16'(wrapped), 16'd1);

        n = 0;
        for (int i = 0; i < 10000; i++) begin
            p = 16'($urandom);
            if (i % 4 == 1) p[10:8] = 3'd0;
            if (i % 4 == 2) p[2:0] = 3'd0;
            if (i % 4 == 3) begin
                p[10:8] = 3'd0;
                p[2:0]  = 3'd0;
            end
            run_block(enc(p), p, 0);
            n++;
        end
        check("loop_blocks", 16'(n), 16'd10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
